// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the inverse cipher datapath.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [7:0]   byte_t;

  localparam int NR_128 = 10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} inv_fsm_t;

  // Byte b of the state (column c = b/4, row r = b%4) lives at bits [127-8b -: 8].
  // Row r is rotated right by r bytes: out column c takes in column (c - r) mod 4.
  function automatic state_t inv_shift_rows(input state_t s);
    state_t r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c-row+4)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

  // Multiply by x in GF(2^8), reduction polynomial 0x11B.
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Generic GF(2^8) multiply by shift-and-add.
  function automatic byte_t gmul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Column-wise multiply by the {0e,0b,0d,09} circulant matrix.
  function automatic state_t inv_mix_columns(input state_t s);
    state_t r;
    byte_t  a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      r[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      r[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      r[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return r;
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box: one byte in, one byte out.
module inv_sbox
  import aes_pkg::*;
(
  input  byte_t data,
  output byte_t result
);

  // Entry k occupies bits [2047-8k -: 8], so the table reads in natural order.
  localparam logic [2047:0] INV_SBOX_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  assign result = INV_SBOX_TABLE[11'd2047 - {data, 3'b000} -: 8];

endmodule

// File: rtl/aes_inv_cipher_core.sv
// Iterative AES inverse cipher: one inverse round per clock, round keys fetched
// by index from an external combinational key store.
module aes_inv_cipher_core
  import aes_pkg::*;
#(
  parameter int NR       = NR_128,
  parameter int RK_IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic [127:0]        rk,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data
);

  inv_fsm_t            state_reg, state_next;
  state_t              st_reg, st_next;
  logic [RK_IDX_W-1:0] ctr_reg, ctr_next;

  state_t shifted;
  state_t subbed;
  state_t round_t;

  assign shifted = inv_shift_rows(st_reg);

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
      inv_sbox u_inv_sbox (
        .data   (shifted[127-8*gi -: 8]),
        .result (subbed[127-8*gi -: 8])
      );
    end
  endgenerate

  assign round_t  = subbed ^ rk;
  assign out_data = st_reg;

  // State, round counter and FSM registers; reset aborts any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      st_reg    <= '0;
      ctr_reg   <= RK_IDX_W'(NR - 1);
    end else begin
      state_reg <= state_next;
      st_reg    <= st_next;
      ctr_reg   <= ctr_next;
    end
  end

  // Next-state, round datapath selection and handshake outputs.
  always_comb begin
    state_next = state_reg;
    st_next    = st_reg;
    ctr_next   = ctr_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    rk_idx     = ctr_reg;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        rk_idx   = RK_IDX_W'(NR);
        if (in_valid) begin
          st_next    = in_data ^ rk;
          ctr_next   = RK_IDX_W'(NR - 1);
          state_next = RUN;
        end
      end
      RUN: begin
        if (ctr_reg != '0) begin
          st_next  = inv_mix_columns(round_t);
          ctr_next = ctr_reg - 1'b1;
        end else begin
          // Final round skips InvMixColumns.
          st_next    = round_t;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
